// File: rtl/bf_exec_unit_if.sv
// Executor-side bus: program ROM fetch, tape-memory pulse interface and byte I/O.
// out_* / in_*: a byte moves on a rising edge where valid and ready are both high.
interface bf_exec_unit_if #(
    parameter int PC_WIDTH = 10
);
    logic [PC_WIDTH-1:0] prog_addr;
    logic [7:0]          prog_data;

    logic [7:0]          ptr_value;
    logic [7:0]          ptr_new_value;
    logic                ptr_set_value;
    logic                ptr_move;
    logic                ptr_move_dir;
    logic                roll_back;

    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_ready;

    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ready;

    modport master (
        output prog_addr,
        input  prog_data,
        input  ptr_value,
        output ptr_new_value,
        output ptr_set_value,
        output ptr_move,
        output ptr_move_dir,
        output roll_back,
        output out_data,
        output out_valid,
        input  out_ready,
        input  in_data,
        input  in_valid,
        output in_ready
    );

    modport slave (
        input  prog_addr,
        output prog_data,
        output ptr_value,
        input  ptr_new_value,
        input  ptr_set_value,
        input  ptr_move,
        input  ptr_move_dir,
        input  roll_back,
        input  out_data,
        input  out_valid,
        output out_ready,
        output in_data,
        output in_valid,
        input  in_ready
    );
endinterface

// File: rtl/bf_exec_unit.sv
// Brainfuck instruction executor: fetch/decode from a combinational ROM, loop stack,
// tape pulses to the memory stage and byte I/O handshakes.
module bf_exec_unit #(
    parameter int PC_WIDTH    = 10,
    parameter int STACK_DEPTH = 16
) (
    input  logic                 working_clock,
    input  logic                 reset,
    input  logic                 start,
    bf_exec_unit_if.master       bus,
    output logic                 busy,
    output logic                 halted,
    output logic                 error,
    output logic [3:0]           state_dbg
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam int SD_W = PC_WIDTH + 1;

    localparam logic [7:0] OP_INC  = 8'h2B;
    localparam logic [7:0] OP_DEC  = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT = 8'h3C;
    localparam logic [7:0] OP_OUT  = 8'h2E;
    localparam logic [7:0] OP_IN   = 8'h2C;
    localparam logic [7:0] OP_LOOP = 8'h5B;
    localparam logic [7:0] OP_END  = 8'h5D;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_FETCH = 4'd2,
        S_EXEC  = 4'd3,
        S_SKIP  = 4'd4,
        S_OUT   = 4'd5,
        S_IN    = 4'd6,
        S_HALT  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    state_t              state, state_n;
    logic [PC_WIDTH-1:0] pc, pc_n;
    logic [SP_W-1:0]     sp, sp_n;
    logic [SD_W-1:0]     skip_depth, skip_n;
    logic [7:0]          instr, instr_n;
    logic [7:0]          out_data_q, out_data_n;
    logic                out_valid_q, out_valid_n;
    logic                push;

    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];

    logic [PC_WIDTH-1:0] pc_inc;
    logic [SP_W-1:0]     sp_dec;
    logic [SP_W-2:0]     top_idx;
    logic [SP_W-2:0]     push_idx;
    logic                cell_zero;

    assign pc_inc    = pc + 1'b1;
    assign sp_dec    = sp - 1'b1;
    assign top_idx   = sp_dec[SP_W-2:0];
    assign push_idx  = sp[SP_W-2:0];
    assign cell_zero = (bus.ptr_value == 8'h00);

    always_ff @(posedge working_clock) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            sp          <= '0;
            skip_depth  <= '0;
            instr       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            sp          <= sp_n;
            skip_depth  <= skip_n;
            instr       <= instr_n;
            out_data_q  <= out_data_n;
            out_valid_q <= out_valid_n;
        end
    end

    // Loop-start addresses; contents are only meaningful below sp, so no reset.
    always_ff @(posedge working_clock) begin
        if (push) begin
            stack[push_idx] <= pc;
        end
    end

    always_comb begin
        state_n           = state;
        pc_n              = pc;
        sp_n              = sp;
        skip_n            = skip_depth;
        instr_n           = instr;
        out_data_n        = out_data_q;
        out_valid_n       = out_valid_q;
        push              = 1'b0;
        bus.ptr_set_value = 1'b0;
        bus.ptr_new_value = 8'h00;
        bus.ptr_move      = 1'b0;
        bus.ptr_move_dir  = 1'b0;
        bus.roll_back     = 1'b0;
        bus.in_ready      = 1'b0;

        case (state)
            S_IDLE, S_HALT, S_ERR: begin
                if (start) begin
                    state_n = S_START;
                    pc_n    = '0;
                    sp_n    = '0;
                    skip_n  = '0;
                end
            end

            S_START: begin
                bus.roll_back = 1'b1;
                state_n       = S_FETCH;
            end

            S_FETCH: begin
                instr_n = bus.prog_data;
                if (bus.prog_data == 8'h00) begin
                    state_n = S_HALT;
                end else begin
                    state_n = S_EXEC;
                end
            end

            S_EXEC: begin
                state_n = S_FETCH;
                pc_n    = pc_inc;
                case (instr)
                    OP_INC: begin
                        bus.ptr_set_value = 1'b1;
                        bus.ptr_new_value = bus.ptr_value + 8'h01;
                    end
                    OP_DEC: begin
                        bus.ptr_set_value = 1'b1;
                        bus.ptr_new_value = bus.ptr_value - 8'h01;
                    end
                    OP_RIGHT: begin
                        bus.ptr_move     = 1'b1;
                        bus.ptr_move_dir = 1'b1;
                    end
                    OP_LEFT: begin
                        bus.ptr_move     = 1'b1;
                        bus.ptr_move_dir = 1'b0;
                    end
                    OP_OUT: begin
                        pc_n        = pc;
                        out_data_n  = bus.ptr_value;
                        out_valid_n = 1'b1;
                        state_n     = S_OUT;
                    end
                    OP_IN: begin
                        pc_n    = pc;
                        state_n = S_IN;
                    end
                    OP_LOOP: begin
                        if (cell_zero) begin
                            skip_n  = SD_W'(1);
                            state_n = S_SKIP;
                        end else if (sp == SP_W'(STACK_DEPTH)) begin
                            pc_n    = pc;
                            state_n = S_ERR;
                        end else begin
                            push = 1'b1;
                            sp_n = sp + 1'b1;
                        end
                    end
                    OP_END: begin
                        if (sp == '0) begin
                            pc_n    = pc;
                            state_n = S_ERR;
                        end else if (!cell_zero) begin
                            // Re-enter the body just after the matching '['; entry stays pushed.
                            pc_n = stack[top_idx] + 1'b1;
                        end else begin
                            sp_n = sp_dec;
                        end
                    end
                    default: ;
                endcase
            end

            S_SKIP: begin
                pc_n = pc_inc;
                case (bus.prog_data)
                    OP_LOOP: skip_n = skip_depth + 1'b1;
                    OP_END: begin
                        skip_n = skip_depth - 1'b1;
                        if (skip_depth == SD_W'(1)) begin
                            state_n = S_FETCH;
                        end
                    end
                    8'h00: begin
                        pc_n    = pc;
                        state_n = S_ERR;
                    end
                    default: ;
                endcase
            end

            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_n = 1'b0;
                    pc_n        = pc_inc;
                    state_n     = S_FETCH;
                end
            end

            S_IN: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.ptr_set_value = 1'b1;
                    bus.ptr_new_value = bus.in_data;
                    pc_n              = pc_inc;
                    state_n           = S_FETCH;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    assign bus.prog_addr = pc;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

    assign busy      = !(state == S_IDLE || state == S_HALT || state == S_ERR);
    assign halted    = (state == S_HALT);
    assign error     = (state == S_ERR);
    assign state_dbg = state;
endmodule

// File: tb/tb_bf_exec_unit.sv
// Bench for bf_exec_unit: ROM and tape-memory models, output-byte scoreboard,
// directed programs covering arithmetic wrap, loops, skip, I/O stalls, errors and reset.
module tb_bf_exec_unit;
    localparam int PC_WIDTH    = 10;
    localparam int STACK_DEPTH = 16;
    localparam int ROM_SIZE    = 1 << PC_WIDTH;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_SKIP = 4'd4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       busy, halted, error;
    logic [3:0] state_dbg;

    bf_exec_unit_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    bf_exec_unit #(
        .PC_WIDTH    (PC_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .working_clock (clk),
        .reset         (rst),
        .start         (start),
        .bus           (bus),
        .busy          (busy),
        .halted        (halted),
        .error         (error),
        .state_dbg     (state_dbg)
    );

    // program ROM model
    logic [7:0] rom [ROM_SIZE];
    assign bus.prog_data = rom[bus.prog_addr];

    // tape memory model: 16 cells, pointer clamped at both ends
    logic [7:0] tape [16];
    logic [3:0] tptr;
    logic       tape_clear;

    always @(posedge clk) begin
        if (tape_clear) begin
            for (int i = 0; i < 16; i++) tape[i] <= 8'h00;
            tptr <= 4'd0;
        end else begin
            if (bus.roll_back) tptr <= 4'd0;
            else if (bus.ptr_move) begin
                if (bus.ptr_move_dir && tptr != 4'd15) tptr <= tptr + 4'd1;
                else if (!bus.ptr_move_dir && tptr != 4'd0) tptr <= tptr - 4'd1;
            end
            if (bus.ptr_set_value) tape[tptr] <= bus.ptr_new_value;
        end
    end
    assign bus.ptr_value = tape[tptr];

    // scoreboard
    logic [7:0] exp_q [$];
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // monitor: pulse counters, backward pc jumps, output pops
    int   cnt_set, cnt_move, cnt_rb, cnt_back, cnt_outv;
    logic cnt_clear;
    logic [PC_WIDTH-1:0] prev_addr;
    logic prev_busy;

    always @(negedge clk) begin
        if (cnt_clear) begin
            cnt_set = 0; cnt_move = 0; cnt_rb = 0; cnt_back = 0; cnt_outv = 0;
        end else if (!rst) begin
            check("pulse_multi",
                  32'((int'(bus.ptr_set_value) + int'(bus.ptr_move) + int'(bus.roll_back)) > 1), 32'd0);
            if (bus.ptr_set_value) cnt_set++;
            if (bus.ptr_move)      cnt_move++;
            if (bus.roll_back)     cnt_rb++;
            if (bus.out_valid)     cnt_outv++;
            if (prev_busy && busy && bus.prog_addr < prev_addr) cnt_back++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("out_unexpected", {24'd0, bus.out_data}, 32'hFFFF_FFFF);
                else check("out_data", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_addr = bus.prog_addr;
        prev_busy = busy;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input string s);
        for (int i = 0; i < ROM_SIZE; i++) rom[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) rom[i] = s[i];
    endtask

    task automatic prep(input string s);
        load_prog(s);
        tape_clear = 1'b1;
        cnt_clear  = 1'b1;
        tick();
        tape_clear = 1'b0;
        cnt_clear  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run(input string s, input bit exp_err);
        bit ok;
        prep(s);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (halted || error) begin
                ok = 1'b1;
                break;
            end
        end
        check("run_done", 32'(ok), 32'd1);
        check("error_flag", 32'(error), 32'(exp_err));
        check("halted_flag", 32'(halted), 32'(!exp_err));
        check("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic quiet_after_error();
        int snap;
        snap = cnt_set + cnt_move + cnt_rb;
        repeat (6) @(negedge clk);
        check("quiet_after_err", 32'(cnt_set + cnt_move + cnt_rb), 32'(snap));
        check("error_held", 32'(error), 32'd1);
    endtask

    task automatic recover();
        exp_q.push_back(8'h01);
        run("+.", 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_outs"},
              {bus.ptr_new_value, bus.ptr_set_value, bus.ptr_move, bus.ptr_move_dir, bus.roll_back,
               bus.out_data, bus.out_valid, bus.in_ready, busy, halted, error},
              32'd0);
        check({tag, "_pc"}, 32'(bus.prog_addr), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    task automatic feed_byte(input logic [7:0] b, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_in_ready_seen"}, 32'(seen), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check({tag, "_in_ready_hold"}, 32'(bus.in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    initial begin
        string s;
        bit    seen;

        rst            = 1'b1;
        start          = 1'b0;
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        tape_clear     = 1'b1;
        cnt_clear      = 1'b1;
        load_prog("");
        repeat (3) tick();
        @(negedge clk);
        check_reset_state("reset");
        rst        = 1'b0;
        tape_clear = 1'b0;
        cnt_clear  = 1'b0;
        tick();

        // increment, output, halt
        exp_q.push_back(8'h03);
        run("+++.", 1'b0);
        check("inc_roll_back_cnt", 32'(cnt_rb), 32'd1);
        check("inc_out_valid_cycles", 32'(cnt_outv), 32'd1);
        check("inc_set_cnt", 32'(cnt_set), 32'd3);

        // decrement wraps 00 -> FF
        exp_q.push_back(8'hFF);
        run("-.", 1'b0);

        // loop body runs twice; the ']' jumps back once, then falls through
        exp_q.push_back(8'h00);
        run("++[-].", 1'b0);
        check("loop_set_cnt", 32'(cnt_set), 32'd4);
        check("loop_back_jumps", 32'(cnt_back), 32'd1);

        // nested skip from a zero cell
        exp_q.push_back(8'h00);
        run("[+[+]+].", 1'b0);
        check("skip_no_sets", 32'(cnt_set), 32'd0);
        check("skip_halt_pc", 32'(bus.prog_addr), 32'd8);

        // input/output with stalls
        prep(",>,<.");
        exp_q.push_back(8'h41);
        bus.out_ready = 1'b0;
        pulse_start();
        feed_byte(8'h41, "in0");
        feed_byte(8'h42, "in1");
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("io_out_valid_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("io_out_valid_hold", 32'(bus.out_valid), 32'd1);
            check("io_out_data_hold", 32'(bus.out_data), 32'h41);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (halted) begin
                seen = 1'b1;
                break;
            end
        end
        check("io_halted", 32'(seen), 32'd1);
        check("io_set_cnt", 32'(cnt_set), 32'd2);
        check("io_move_cnt", 32'(cnt_move), 32'd2);
        check("io_cell0", 32'(tape[0]), 32'h41);
        check("io_cell1", 32'(tape[1]), 32'h42);

        // exactly STACK_DEPTH nested '[' is legal
        s = "+";
        for (int i = 0; i < STACK_DEPTH; i++) s = {s, "["};
        s = {s, "-"};
        for (int i = 0; i < STACK_DEPTH; i++) s = {s, "]"};
        s = {s, "."};
        exp_q.push_back(8'h00);
        run(s, 1'b0);
        check("depth_ok_back_jumps", 32'(cnt_back), 32'd0);

        // stack overflow
        s = "+";
        for (int i = 0; i < STACK_DEPTH + 1; i++) s = {s, "["};
        run(s, 1'b1);
        quiet_after_error();
        recover();

        // unmatched ']'
        run("]", 1'b1);
        quiet_after_error();
        recover();

        // unmatched '[' found by the skip scan
        run("[", 1'b1);
        quiet_after_error();
        recover();

        // reset while waiting in OUT
        prep("+.");
        bus.out_ready = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_out_reached", 32'(seen), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_state("rst_in_out");
        exp_q.delete();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        recover();

        // reset while scanning in SKIP
        s = "[";
        for (int i = 0; i < 20; i++) s = {s, "+"};
        s = {s, "]"};
        prep(s);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (state_dbg == ST_SKIP) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_skip_reached", 32'(seen), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_state("rst_in_skip");
        rst = 1'b0;
        recover();

        // final report
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
